// File: rtl/uart_fifo_rd_ctrl_if.sv
// uart_fifo_rd_ctrl_if: read-side FIFO signals between the controller and memory/sync/serializer
interface uart_fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH:0]   wptr_sync;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   gptr;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    modport master (
        input  wptr_sync, mem_data, ready,
        output addr, gptr, empty, count, data, valid
    );
    modport slave (
        output wptr_sync, mem_data, ready,
        input  addr, gptr, empty, count, data, valid
    );
endinterface

// File: rtl/uart_fifo_rd_ctrl.sv
// uart_fifo_rd_ctrl: async FIFO read-side pointers, empty/count flags and registered output stage
module uart_fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    i_fifo_rd_clk,
    input  logic                    i_fifo_rd_rst_n,
    uart_fifo_rd_ctrl_if.master     rd
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [PW-1:0]         rbin_q, rbin_d, rgray_q, rgray_d, count_q, count_d;
    logic                  empty_q, empty_d, valid_q, valid_d, pop;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        for (int i = 0; i < PW; i++) g2b[i] = ^(g >> i);
    endfunction
    // next-state: pop when memory has a word and the output stage is free or draining
    always_comb begin
        pop     = !empty_q && (!valid_q || rd.ready);
        rbin_d  = pop ? rbin_q + 1'b1 : rbin_q;
        rgray_d = rbin_d ^ (rbin_d >> 1);
        data_d  = pop ? rd.mem_data : data_q;
        valid_d = pop || (valid_q && !rd.ready);
        empty_d = rgray_d == rd.wptr_sync;
        count_d = g2b(rd.wptr_sync) - rbin_d;
    end
    // state registers, asynchronously cleared
    always_ff @(posedge i_fifo_rd_clk or negedge i_fifo_rd_rst_n) begin
        if (!i_fifo_rd_rst_n) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
    assign rd.addr  = rbin_q[ADDR_WIDTH-1:0];
    assign rd.gptr  = rgray_q;
    assign rd.empty = empty_q;
    assign rd.count = count_q;
    assign rd.data  = data_q;
    assign rd.valid = valid_q;
endmodule

// File: tb/tb_uart_fifo_rd_ctrl.sv
// tb_uart_fifo_rd_ctrl: directed tests of the FIFO read-side controller with a modelled write side
module tb_uart_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [DW-1:0] mem [2**AW];
    logic [AW:0] wbin;
    int n_checks = 0;
    int n_fail = 0;
    uart_fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rd();
    uart_fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_fifo_rd_clk   (clk),
        .i_fifo_rd_rst_n (rst_n),
        .rd              (rd)
    );
    always #5 clk = ~clk;
    assign rd.mem_data = mem[rd.addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wbin[AW-1:0]] = w;
        wbin = wbin + 1'b1;
        rd.wptr_sync = wbin ^ (wbin >> 1);
    endtask

    task automatic test_reset();
        #23;
        n_checks += 6;
        if (rd.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rd.valid); end
        if (rd.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", rd.empty); end
        if (rd.gptr !== 4'b0000) begin n_fail++; $display("FAIL reset_gptr got %b exp 0000", rd.gptr); end
        if (rd.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", rd.count); end
        if (rd.addr !== 3'b000) begin n_fail++; $display("FAIL reset_addr got %b exp 000", rd.addr); end
        if (rd.data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rd.data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        push(8'hA5);
        step();
        n_checks += 3;
        if (rd.empty !== 1'b0) begin n_fail++; $display("FAIL single_e1_empty got %b exp 0", rd.empty); end
        if (rd.count !== 4'd1) begin n_fail++; $display("FAIL single_e1_count got %0d exp 1", rd.count); end
        if (rd.valid !== 1'b0) begin n_fail++; $display("FAIL single_e1_valid got %b exp 0", rd.valid); end
        step();
        n_checks += 5;
        if (rd.valid !== 1'b1) begin n_fail++; $display("FAIL single_e2_valid got %b exp 1", rd.valid); end
        if (rd.data !== 8'hA5) begin n_fail++; $display("FAIL single_e2_data got %h exp a5", rd.data); end
        if (rd.gptr !== 4'b0001) begin n_fail++; $display("FAIL single_e2_gptr got %b exp 0001", rd.gptr); end
        if (rd.empty !== 1'b1) begin n_fail++; $display("FAIL single_e2_empty got %b exp 1", rd.empty); end
        if (rd.count !== 4'd0) begin n_fail++; $display("FAIL single_e2_count got %0d exp 0", rd.count); end
        rd.ready = 1'b1;
        step();
        n_checks++;
        if (rd.valid !== 1'b0) begin n_fail++; $display("FAIL single_accept_valid got %b exp 0", rd.valid); end
        rd.ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        step();
        n_checks++;
        if (rd.count !== 4'd4) begin n_fail++; $display("FAIL bp_count_pre got %0d exp 4", rd.count); end
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks += 3;
            if (rd.valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", k, rd.valid); end
            if (rd.data !== 8'hB0) begin n_fail++; $display("FAIL bp_hold_data[%0d] got %h exp b0", k, rd.data); end
            if (rd.count !== 4'd3) begin n_fail++; $display("FAIL bp_hold_count[%0d] got %0d exp 3", k, rd.count); end
        end
        rd.ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            n_checks += 3;
            if (rd.valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid[%0d] got %b exp 1", k, rd.valid); end
            if (rd.data !== 8'hB0 + 8'(k)) begin n_fail++; $display("FAIL bp_drain_data[%0d] got %h exp %h", k, rd.data, 8'hB0 + 8'(k)); end
            if (rd.count !== 4'(3 - k)) begin n_fail++; $display("FAIL bp_drain_count[%0d] got %0d exp %0d", k, rd.count, 3 - k); end
        end
        step();
        n_checks += 2;
        if (rd.valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid got %b exp 0", rd.valid); end
        if (rd.empty !== 1'b1) begin n_fail++; $display("FAIL bp_end_empty got %b exp 1", rd.empty); end
    endtask

    task automatic test_wrap();
        int got = 0;
        logic seen8 = 1'b0;
        logic seen0 = 1'b0;
        logic [AW:0] prev = rd.gptr;
        for (int c = 0; c < 32; c++) begin
            if (c < 20) push(8'h10 + 8'(c));
            step();
            n_checks++;
            if ($countones(prev ^ rd.gptr) > 1) begin n_fail++; $display("FAIL wrap_gray_step got %b from %b exp one bit change", rd.gptr, prev); end
            prev = rd.gptr;
            if (rd.valid) begin
                n_checks++;
                if (rd.data !== 8'h10 + 8'(got)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", got, rd.data, 8'h10 + 8'(got)); end
                got++;
            end
            if (rd.gptr == 4'b1000) seen8 = 1'b1;
            if (seen8 && rd.gptr == 4'b0000) seen0 = 1'b1;
        end
        n_checks += 3;
        if (got != 20) begin n_fail++; $display("FAIL wrap_words got %0d exp 20", got); end
        if (seen0 !== 1'b1) begin n_fail++; $display("FAIL wrap_gptr_1000_then_0000 got %b exp 1", seen0); end
        if (rd.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end_empty got %b exp 1", rd.empty); end
    endtask

    task automatic test_full();
        int got = 0;
        @(negedge clk);
        rst_n = 1'b0;
        rd.ready = 1'b0;
        wbin = '0;
        rd.wptr_sync = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        step();
        n_checks += 3;
        if (rd.count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d exp 8", rd.count); end
        if (rd.empty !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b exp 0", rd.empty); end
        if (rd.addr !== 3'b000) begin n_fail++; $display("FAIL full_addr got %b exp 000", rd.addr); end
        rd.ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rd.valid) begin
                n_checks++;
                if (rd.data !== 8'h60 + 8'(got)) begin n_fail++; $display("FAIL full_data[%0d] got %h exp %h", got, rd.data, 8'h60 + 8'(got)); end
                got++;
            end
        end
        n_checks += 3;
        if (got != 8) begin n_fail++; $display("FAIL full_words got %0d exp 8", got); end
        if (rd.empty !== 1'b1) begin n_fail++; $display("FAIL full_end_empty got %b exp 1", rd.empty); end
        if (rd.count !== 4'd0) begin n_fail++; $display("FAIL full_end_count got %0d exp 0", rd.count); end
    endtask

    task automatic test_reset_mid();
        rd.ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        step();
        step();
        n_checks += 2;
        if (rd.valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", rd.valid); end
        if (rd.count !== 4'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d exp 3", rd.count); end
        #2;
        rst_n = 1'b0;
        wbin = '0;
        rd.wptr_sync = '0;
        #1;
        n_checks += 6;
        if (rd.valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b exp 0", rd.valid); end
        if (rd.empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b exp 1", rd.empty); end
        if (rd.gptr !== 4'b0000) begin n_fail++; $display("FAIL mid_gptr got %b exp 0000", rd.gptr); end
        if (rd.count !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d exp 0", rd.count); end
        if (rd.addr !== 3'b000) begin n_fail++; $display("FAIL mid_addr got %b exp 000", rd.addr); end
        if (rd.data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h exp 00", rd.data); end
        @(negedge clk);
        rst_n = 1'b1;
        push(8'hC7);
        step();
        n_checks += 2;
        if (rd.addr !== 3'b000) begin n_fail++; $display("FAIL mid_new_addr got %b exp 000", rd.addr); end
        if (rd.count !== 4'd1) begin n_fail++; $display("FAIL mid_new_count got %0d exp 1", rd.count); end
        step();
        n_checks += 3;
        if (rd.valid !== 1'b1) begin n_fail++; $display("FAIL mid_new_valid got %b exp 1", rd.valid); end
        if (rd.data !== 8'hC7) begin n_fail++; $display("FAIL mid_new_data got %h exp c7", rd.data); end
        if (rd.gptr !== 4'b0001) begin n_fail++; $display("FAIL mid_new_gptr got %b exp 0001", rd.gptr); end
    endtask

    initial begin
        wbin = '0;
        rd.wptr_sync = '0;
        rd.ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'hEE;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
